// File: rtl/iomem_port_irq.sv
// Memory-mapped 8-bit output port, synchronized 8-bit input port and
// per-bit edge-triggered interrupt flags behind a valid/ready iomem handshake.
`timescale 1ns/1ps
module iomem_port_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [7:0]  porta_out,
    input  logic [7:0]  portb_in,
    output logic        irq_out
);

    localparam logic [7:0] OFF_PORTA    = 8'h00;
    localparam logic [7:0] OFF_PORTB    = 8'h04;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h08;
    localparam logic [7:0] OFF_IRQ_FLAG = 8'h0C;
    localparam logic [7:0] OFF_EDGE_SEL = 8'h10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t      state_r;
    logic        iomem_ready_r;
    logic [31:0] iomem_rdata_r;
    logic [7:0]  porta_r;
    logic [7:0]  irq_en_r;
    logic [7:0]  irq_flag_r;
    logic [7:0]  edge_sel_r;
    logic [7:0]  sync1_r;
    logic [7:0]  sync2_r;
    logic [7:0]  hist_r;
    logic        irq_r;

    logic        hit_s;
    logic        accept_s;
    logic        write_s;
    logic        read_s;
    logic [7:0]  offset_s;
    logic [7:0]  rd_byte_s;
    logic [7:0]  w1c_s;
    logic [7:0]  edge_evt_s;
    logic [7:0]  irq_flag_next_s;

    // Bit i selects rising (sel=0) or falling (sel=1) detection on synchronized input.
    function automatic logic [7:0] edge_events(input logic [7:0] cur,
                                               input logic [7:0] prev,
                                               input logic [7:0] sel);
        edge_events = (~sel & cur & ~prev) | (sel & ~cur & prev);
    endfunction

    // Address decode and request qualification.
    always_comb begin
        offset_s = iomem_addr[7:0];
        hit_s    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
        accept_s = hit_s && (state_r == ST_IDLE) && !iomem_ready_r;
        write_s  = accept_s && iomem_wstrb[0];
        read_s   = accept_s && (iomem_wstrb == 4'h0);
    end

    // Read multiplexer; unmapped offsets read as zero.
    always_comb begin
        rd_byte_s = 8'h00;
        case (offset_s)
            OFF_PORTA:    rd_byte_s = porta_r;
            OFF_PORTB:    rd_byte_s = sync2_r;
            OFF_IRQ_EN:   rd_byte_s = irq_en_r;
            OFF_IRQ_FLAG: rd_byte_s = irq_flag_r;
            OFF_EDGE_SEL: rd_byte_s = edge_sel_r;
            default:      rd_byte_s = 8'h00;
        endcase
    end

    // Flag update: a fresh edge event wins over a same-cycle write-1-to-clear.
    always_comb begin
        w1c_s      = 8'h00;
        edge_evt_s = edge_events(sync2_r, hist_r, edge_sel_r);
        if (write_s && (offset_s == OFF_IRQ_FLAG)) begin
            w1c_s = iomem_wdata[7:0];
        end else begin
            w1c_s = 8'h00;
        end
        irq_flag_next_s = (irq_flag_r & ~w1c_s) | edge_evt_s;
    end

    // Handshake FSM with registered ready and read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            iomem_ready_r <= 1'b0;
            iomem_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r       <= ST_ACK;
                        iomem_ready_r <= 1'b1;
                        iomem_rdata_r <= read_s ? {24'h00_0000, rd_byte_s} : 32'h0000_0000;
                    end else begin
                        state_r       <= ST_IDLE;
                        iomem_ready_r <= 1'b0;
                        iomem_rdata_r <= 32'h0000_0000;
                    end
                end
                ST_ACK: begin
                    state_r       <= ST_IDLE;
                    iomem_ready_r <= 1'b0;
                    iomem_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    iomem_ready_r <= 1'b0;
                    iomem_rdata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Register file, input synchronizer and interrupt output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            porta_r    <= 8'h00;
            irq_en_r   <= 8'h00;
            irq_flag_r <= 8'h00;
            edge_sel_r <= 8'h00;
            sync1_r    <= 8'h00;
            sync2_r    <= 8'h00;
            hist_r     <= 8'h00;
            irq_r      <= 1'b0;
        end else begin
            if (write_s) begin
                case (offset_s)
                    OFF_PORTA:    porta_r    <= iomem_wdata[7:0];
                    OFF_IRQ_EN:   irq_en_r   <= iomem_wdata[7:0];
                    OFF_EDGE_SEL: edge_sel_r <= iomem_wdata[7:0];
                    default:      porta_r    <= porta_r;
                endcase
            end
            irq_flag_r <= irq_flag_next_s;
            sync1_r    <= portb_in;
            sync2_r    <= sync1_r;
            hist_r     <= sync2_r;
            irq_r      <= |(irq_flag_r & irq_en_r);
        end
    end

    assign iomem_ready = iomem_ready_r;
    assign iomem_rdata = iomem_rdata_r;
    assign porta_out   = porta_r;
    assign irq_out     = irq_r;

endmodule
